tdm_demux_1to4: RTL and testbench

Four-channel time-division demultiplexer: the receiving end of a 4:1 channel multiplexer link. It accepts one sample per `in_valid` beat from a shared serial slot stream, uses `fsync` to locate slot 0, and distributes slots 0..3 to four registered outputs. It presents a complete frame with a one-cycle `out_valid` pulse, and it detects and recovers from frame-alignment loss.

---
 rtl/tdm_demux_1to4.sv | 156 +++++++++++++++
 tb/tb_tdm_demux_1to4.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: receive side of a 4:1 time-division channel link.
// Samples arrive one per in_valid beat. fsync marks the slot-0 beat. The
// samples are collected into shadow registers and copied out as one frame
// when slot 3 arrives. Alignment loss is detected, flagged and recovered.
module tdm_demux_1to4 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             fsync,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic             out_valid,
   output logic [1:0]       slot,
   output logic             locked,
   output logic             sync_err
);

   // HUNT waits for fsync. LOCKED tracks slots and expects fsync only on slot 0.
   typedef enum logic {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       slot_q, slot_d;
   logic [WIDTH-1:0] sh_q  [3];
   logic [WIDTH-1:0] sh_d  [3];
   logic [WIDTH-1:0] out_q [4];
   logic [WIDTH-1:0] out_d [4];
   logic             out_valid_q, out_valid_d;
   logic             sync_err_q, sync_err_d;

   // Beat qualification. fsync has no meaning without in_valid.
   logic beat_sync;
   logic beat_plain;

   assign beat_sync  = in_valid & fsync;
   assign beat_plain = in_valid & ~fsync;

   // Next-state logic: decode the beat against the state and the expected slot.
   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      sh_d        = sh_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      sync_err_d  = 1'b0;

      unique case (state_q)
         ST_HUNT: begin
            // Beats without fsync are dropped. The slot counter stays at 0.
            if (beat_sync) begin
               sh_d[0] = in_data;
               slot_d  = 2'd1;
               state_d = ST_LOCKED;
            end
         end

         ST_LOCKED: begin
            if (beat_sync) begin
               // fsync always starts a new frame. If it arrives on slot 1..3,
               // the frame in progress is dropped and an error is flagged. The
               // outputs are not touched, so a partial frame never appears there.
               if (slot_q != 2'd0) begin
                  sync_err_d = 1'b1;
               end
               sh_d[0] = in_data;
               slot_d  = 2'd1;
            end else if (beat_plain) begin
               unique case (slot_q)
                  2'd0: begin
                     // fsync was expected on this beat. Drop the beat and return to HUNT.
                     sync_err_d = 1'b1;
                     state_d    = ST_HUNT;
                     slot_d     = 2'd0;
                  end
                  2'd1: begin
                     sh_d[1] = in_data;
                     slot_d  = 2'd2;
                  end
                  2'd2: begin
                     sh_d[2] = in_data;
                     slot_d  = 2'd3;
                  end
                  2'd3: begin
                     // Frame complete. Slot 3 goes straight to out3 on this edge.
                     out_d[0]    = sh_q[0];
                     out_d[1]    = sh_q[1];
                     out_d[2]    = sh_q[2];
                     out_d[3]    = in_data;
                     out_valid_d = 1'b1;
                     slot_d      = 2'd0;
                  end
                  default: begin
                     slot_d = 2'd0;
                  end
               endcase
            end
         end

         default: begin
            state_d = ST_HUNT;
            slot_d  = 2'd0;
         end
      endcase
   end

   // Control registers: state, slot counter and the one-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_HUNT;
         slot_q      <= 2'd0;
         out_valid_q <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         out_valid_q <= out_valid_d;
         sync_err_q  <= sync_err_d;
      end
   end

   // Data registers: the shadow bank for the frame in progress and the output bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            sh_q[i] <= '0;
         end
         for (int i = 0; i < 4; i++) begin
            out_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            sh_q[i] <= sh_d[i];
         end
         for (int i = 0; i < 4; i++) begin
            out_q[i] <= out_d[i];
         end
      end
   end

   assign out0      = out_q[0];
   assign out1      = out_q[1];
   assign out2      = out_q[2];
   assign out3      = out_q[3];
   assign out_valid = out_valid_q;
   assign sync_err  = sync_err_q;
   assign slot      = slot_q;
   assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Testbench for tdm_demux_1to4 with WIDTH=4. It applies directed beat
// vectors from a table and then runs a hand-written asynchronous reset sequence.
module tb_tdm_demux_1to4;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         fsync;
   logic [W-1:0] out0, out1, out2, out3;
   logic         out_valid;
   logic [1:0]   slot;
   logic         locked;
   logic         sync_err;

   int errors = 0;
   int checks = 0;

   tdm_demux_1to4 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .fsync     (fsync),
      .out0      (out0),
      .out1      (out1),
      .out2      (out2),
      .out3      (out3),
      .out_valid (out_valid),
      .slot      (slot),
      .locked    (locked),
      .sync_err  (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One stimulus beat, plus the state required after the edge that samples it.
   typedef struct {
      logic        v;
      logic        f;
      logic [3:0]  d;
      logic [15:0] o;
      logic        ov;
      logic        se;
      logic        lk;
      logic [1:0]  sl;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic v, input logic f, input logic [3:0] d,
                      input logic [15:0] o, input logic ov, input logic se,
                      input logic lk, input logic [1:0] sl);
      vec_t x;
      x.v = v; x.f = f; x.d = d; x.o = o;
      x.ov = ov; x.se = se; x.lk = lk; x.sl = sl;
      vecs.push_back(x);
   endtask

   // Packed view of every output: {out0..out3, out_valid, sync_err, locked, slot}.
   function automatic logic [20:0] snap();
      return {out0, out1, out2, out3, out_valid, sync_err, locked, slot};
   endfunction

   task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got outs=%h ov=%b se=%b lk=%b sl=%0d, want outs=%h ov=%b se=%b lk=%b sl=%0d",
                  name, act[20:5], act[4], act[3], act[2], act[1:0],
                  exp[20:5], exp[4], exp[3], exp[2], exp[1:0]);
      end else begin
         $display("ok   %s: outs=%h ov=%b se=%b lk=%b sl=%0d",
                  name, act[20:5], act[4], act[3], act[2], act[1:0]);
      end
   endtask

   // Apply a beat at the falling edge, then sample shortly after the rising edge.
   task automatic beat(input logic v, input logic f, input logic [3:0] d);
      @(negedge clk);
      in_valid = v;
      fsync    = f;
      in_data  = d;
      @(posedge clk);
      #2;
   endtask

   // Time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      in_valid = 1'b0;
      fsync    = 1'b0;
      in_data  = '0;
      rst_n    = 1'b1;
      #1 rst_n = 1'b0;
      #1 check("reset_state", snap(), 21'h0);
      @(negedge clk);
      rst_n = 1'b1;

      //   v  f  d     outs      ov se lk sl
      // Basic frame
      add(1, 1, 4'hA, 16'h0000, 0, 0, 1, 1);
      add(1, 0, 4'h5, 16'h0000, 0, 0, 1, 2);
      add(1, 0, 4'h3, 16'h0000, 0, 0, 1, 3);
      add(1, 0, 4'hC, 16'hA53C, 1, 0, 1, 0);
      // Idle cycle with fsync high: fsync is ignored without in_valid
      add(0, 1, 4'hF, 16'hA53C, 0, 0, 1, 0);
      // Missing sync: drop to HUNT, outputs held
      add(1, 0, 4'h3, 16'hA53C, 0, 1, 0, 0);
      // HUNT discard, then a full frame
      add(1, 0, 4'h1, 16'hA53C, 0, 0, 0, 0);
      add(1, 0, 4'h2, 16'hA53C, 0, 0, 0, 0);
      add(1, 1, 4'h4, 16'hA53C, 0, 0, 1, 1);
      add(1, 0, 4'h6, 16'hA53C, 0, 0, 1, 2);
      add(1, 0, 4'h8, 16'hA53C, 0, 0, 1, 3);
      add(1, 0, 4'hF, 16'h468F, 1, 0, 1, 0);
      // Gapped frame 1..4 (two idle cycles between beats)
      add(1, 1, 4'h1, 16'h468F, 0, 0, 1, 1);
      add(0, 0, 4'h0, 16'h468F, 0, 0, 1, 1);
      add(0, 0, 4'h0, 16'h468F, 0, 0, 1, 1);
      add(1, 0, 4'h2, 16'h468F, 0, 0, 1, 2);
      add(0, 0, 4'h0, 16'h468F, 0, 0, 1, 2);
      add(0, 0, 4'h0, 16'h468F, 0, 0, 1, 2);
      add(1, 0, 4'h3, 16'h468F, 0, 0, 1, 3);
      add(0, 0, 4'h0, 16'h468F, 0, 0, 1, 3);
      add(0, 0, 4'h0, 16'h468F, 0, 0, 1, 3);
      add(1, 0, 4'h4, 16'h1234, 1, 0, 1, 0);
      // Back-to-back frame 9,A,B,C
      add(1, 1, 4'h9, 16'h1234, 0, 0, 1, 1);
      add(1, 0, 4'hA, 16'h1234, 0, 0, 1, 2);
      add(1, 0, 4'hB, 16'h1234, 0, 0, 1, 3);
      add(1, 0, 4'hC, 16'h9ABC, 1, 0, 1, 0);
      // Early sync at slot 2
      add(1, 1, 4'h1, 16'h9ABC, 0, 0, 1, 1);
      add(1, 0, 4'h2, 16'h9ABC, 0, 0, 1, 2);
      add(1, 1, 4'h7, 16'h9ABC, 0, 1, 1, 1);
      add(1, 0, 4'h8, 16'h9ABC, 0, 0, 1, 2);
      add(1, 0, 4'h9, 16'h9ABC, 0, 0, 1, 3);
      add(1, 0, 4'hA, 16'h789A, 1, 0, 1, 0);
      // Early sync at slot 3: the partial frame must not reach the outputs
      add(1, 1, 4'h5, 16'h789A, 0, 0, 1, 1);
      add(1, 0, 4'h6, 16'h789A, 0, 0, 1, 2);
      add(1, 0, 4'h7, 16'h789A, 0, 0, 1, 3);
      add(1, 1, 4'h1, 16'h789A, 0, 1, 1, 1);
      add(1, 0, 4'h2, 16'h789A, 0, 0, 1, 2);
      add(1, 0, 4'h3, 16'h789A, 0, 0, 1, 3);
      add(1, 0, 4'h4, 16'h1234, 1, 0, 1, 0);

      foreach (vecs[i]) begin
         beat(vecs[i].v, vecs[i].f, vecs[i].d);
         check($sformatf("vec%0d v=%b f=%b d=%h", i, vecs[i].v, vecs[i].f, vecs[i].d),
               snap(), {vecs[i].o, vecs[i].ov, vecs[i].se, vecs[i].lk, vecs[i].sl});
      end

      // Asynchronous reset in the middle of a frame
      beat(1, 1, 4'hD);
      beat(1, 0, 4'hE);
      check("pre_reset", snap(), {16'h1234, 1'b0, 1'b0, 1'b1, 2'd2});
      in_valid = 1'b0;
      fsync    = 1'b0;
      #1 rst_n = 1'b0;
      #1 check("async_reset_immediate", snap(), 21'h0);
      @(negedge clk);
      rst_n = 1'b1;
      beat(1, 0, 4'h5);
      check("post_reset_no_fsync", snap(), 21'h0);
      beat(1, 1, 4'h6);
      check("post_reset_fsync", snap(), {16'h0000, 1'b0, 1'b0, 1'b1, 2'd1});
      beat(1, 0, 4'h7);
      beat(1, 0, 4'h8);
      beat(1, 0, 4'h9);
      check("post_reset_frame", snap(), {16'h6789, 1'b1, 1'b0, 1'b1, 2'd0});
      beat(0, 0, 4'h0);
      check("post_reset_hold", snap(), {16'h6789, 1'b0, 1'b0, 1'b1, 2'd0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
